vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator with a pixel-fetch handshake and a registered, blank-gated colour output stage.
- Drives the monitor pins directly and exports pixel coordinates and frame/line strobes to the frame-buffer or sprite logic.
- Generalises the fixed 640x480 all-white generator: programmable timings and sync polarities, colour width, start/stop control and a 2-cycle aligned pixel pipeline.

---
 rtl/vga_timing_gen.sv | 187 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with 2-stage colour pipeline
//
// Purpose: runs a pixel/line raster from programmable porch and sync widths. It
// exports coordinates and strobes for the pixel source and drives registered,
// blank-gated colour and sync pins, all aligned 2 cycles after the coordinates.
// Optional feature: define VGA_TESTPATTERN_EN to add input test_mode[1:0].
// Its values select 0 = rgb_in, 1 = 8 colour bars, 2 = 32x32 checkerboard,
// 3 = solid white.
//
// Ports:
//   clk25        pixel clock
//   rst_n        asynchronous active-low reset
//   en           run enable; low returns the raster to IDLE
//   rgb_in       {R,G,B} pixel colour, returned one cycle after pix_req
//   pix_x/pix_y  current raster position (0 while idle)
//   pix_req      current position is visible; fetch that pixel
//   frame_start  pulse at (0,0); line_start pulse at pix_x==0
//   red/green/blue_out, hsync, vsync, active  registered monitor-side outputs
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   CW         = 4,
    localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  XW         = $clog2(H_TOTAL),
    localparam int  YW         = $clog2(V_TOTAL)
) (
    input  logic            clk25,
    input  logic            rst_n,
    input  logic            en,
    input  logic [3*CW-1:0] rgb_in,
`ifdef VGA_TESTPATTERN_EN
    input  logic [1:0]      test_mode,
`endif
    output logic [XW-1:0]   pix_x,
    output logic [YW-1:0]   pix_y,
    output logic            pix_req,
    output logic            frame_start,
    output logic            line_start,
    output logic [CW-1:0]   red_out,
    output logic [CW-1:0]   green_out,
    output logic [CW-1:0]   blue_out,
    output logic            hsync,
    output logic            vsync,
    output logic            active
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_VIS    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_VIS    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic          state;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic          hs_now;
    logic          vs_now;

    // Next raster position; an IDLE->RUN transition and any stop both yield (0,0).
    always_comb begin
        x_nxt = '0;
        y_nxt = '0;
        if (en && state == ST_RUN) begin
            if (pix_x == X_LAST) begin
                y_nxt = (pix_y == Y_LAST) ? '0 : pix_y + 1'b1;
            end else begin
                x_nxt = pix_x + 1'b1;
                y_nxt = pix_y;
            end
        end
    end

    // Strobes are computed from the next position so they describe the
    // coordinates shown in the same cycle.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            state       <= en ? ST_RUN : ST_IDLE;
            pix_x       <= x_nxt;
            pix_y       <= y_nxt;
            pix_req     <= en && (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            frame_start <= en && (x_nxt == '0) && (y_nxt == '0);
            line_start  <= en && (x_nxt == '0);
        end
    end

    assign hs_now = (state == ST_RUN) && (pix_x >= HS_START) && (pix_x < HS_END);
    assign vs_now = (state == ST_RUN) && (pix_y >= VS_START) && (pix_y < VS_END);

    // Stage 1: flags for the position just shown, while the source answers pix_req.
    logic hs_s1;
    logic vs_s1;
    logic vis_s1;
    logic [3*CW-1:0] src_rgb;

`ifdef VGA_TESTPATTERN_EN
    logic [1:0]    tm_s1;
    logic [XW-1:0] x_s1;
    logic          y5_s1;
    logic [2:0]    bar;
    logic [2:0]    bar_rgb;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            tm_s1 <= 2'd0;
            x_s1  <= '0;
            y5_s1 <= 1'b0;
        end else begin
            tm_s1 <= test_mode;
            x_s1  <= pix_x;
            y5_s1 <= pix_y[5];
        end
    end

    always_comb begin
        src_rgb = rgb_in;
        bar     = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_s1 >= XW'(k * (H_ACTIVE / 8))) bar = 3'(k);
        end
        // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to
        // R=~bar[1], G=~bar[2], B=~bar[0].
        bar_rgb = {~bar[1], ~bar[2], ~bar[0]};
        case (tm_s1)
            2'd1:    src_rgb = {{CW{bar_rgb[2]}}, {CW{bar_rgb[1]}}, {CW{bar_rgb[0]}}};
            2'd2:    src_rgb = (x_s1[5] ^ y5_s1) ? '0 : '1;
            2'd3:    src_rgb = '1;
            default: src_rgb = rgb_in;
        endcase
    end
`else
    assign src_rgb = rgb_in;
`endif

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            vis_s1 <= 1'b0;
        end else begin
            hs_s1  <= hs_now;
            vs_s1  <= vs_now;
            vis_s1 <= pix_req;
        end
    end

    // Stage 2: output registers; colour is forced to 0 outside the visible area.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
            hsync     <= ~H_SYNC_POL;
            vsync     <= ~V_SYNC_POL;
            active    <= 1'b0;
        end else begin
            red_out   <= vis_s1 ? src_rgb[3*CW-1:2*CW] : '0;
            green_out <= vis_s1 ? src_rgb[2*CW-1:CW]   : '0;
            blue_out  <= vis_s1 ? src_rgb[CW-1:0]      : '0;
            hsync     <= hs_s1 ? H_SYNC_POL : ~H_SYNC_POL;
            vsync     <= vs_s1 ? V_SYNC_POL : ~V_SYNC_POL;
            active    <= vis_s1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int   HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int   VA = 40, VFP = 2, VS = 3, VBP = 3;
    localparam logic HPOL = 1'b0, VPOL = 1'b1;
    localparam int   HT = HA + HFP + HS + HBP;
    localparam int   VT = VA + VFP + VS + VBP;
    localparam int   FT = HT * VT;
    localparam int   XW = $clog2(HT);
    localparam int   YW = $clog2(VT);

    logic          clk25 = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic [11:0]   rgb_in = 12'h000;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_req, frame_start, line_start;
    logic [3:0]    red_out, green_out, blue_out;
    logic          hsync, vsync, active;
`ifdef VGA_TESTPATTERN_EN
    logic [1:0]    test_mode = 2'd0;
`endif

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .CW(4)
    ) dut (
        .clk25(clk25), .rst_n(rst_n), .en(en), .rgb_in(rgb_in),
`ifdef VGA_TESTPATTERN_EN
        .test_mode(test_mode),
`endif
        .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
        .frame_start(frame_start), .line_start(line_start),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .hsync(hsync), .vsync(vsync), .active(active)
    );

    always #20 clk25 = ~clk25;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: raster position as a function of cycles since RUN began,
    // with a 2-deep history for the pipelined outputs.
    int          n = 0;
    logic        r0 = 0, r1 = 0, r2 = 0;
    int          x0 = 0, y0 = 0, x1 = 0, y1 = 0, x2 = 0, y2 = 0;
    logic [11:0] rgb1 = 0, cur_rgb = 0;
    logic        use_fixed = 0;
    logic [11:0] fixed_rgb = 12'hABC;

    int cnt_line, cnt_frame, cnt_hs, cnt_vs, cnt_act, cnt_abc, cnt_blank_col;

    typedef struct {
        int cycles;
        int e_line;
        int e_frame;
        int e_hs;
        int e_vs;
        int e_act;
    } vec_t;

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] pattern(input int x, input int y, input int tm);
        logic [2:0] bars [8];
        logic [2:0] b;
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        case (tm)
            1: begin
                b = bars[x / (HA / 8)];
                return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
            end
            2: return (((x / 32) + (y / 32)) % 2 == 0) ? 12'hFFF : 12'h000;
            3: return 12'hFFF;
            default: return rgb1;
        endcase
    endfunction

    task automatic check_cycle();
        logic          hs_a, vs_a, act;
        logic [11:0]   ecol;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        int            tm;
        ex = r0 ? XW'(x0) : '0;
        ey = r0 ? YW'(y0) : '0;
        cmp("timing", {pix_x, pix_y, pix_req, frame_start, line_start},
            {ex, ey, r0 && x0 < HA && y0 < VA, r0 && x0 == 0 && y0 == 0, r0 && x0 == 0});
        hs_a = r2 && x2 >= HA + HFP && x2 < HA + HFP + HS;
        vs_a = r2 && y2 >= VA + VFP && y2 < VA + VFP + VS;
        cmp("sync", {hsync, vsync}, {hs_a ? HPOL : ~HPOL, vs_a ? VPOL : ~VPOL});
        act = r2 && x2 < HA && y2 < VA;
        tm = 0;
`ifdef VGA_TESTPATTERN_EN
        tm = int'(test_mode);
`endif
        ecol = act ? pattern(x2, y2, tm) : 12'h000;
        cmp("video", {active, red_out, green_out, blue_out}, {act, ecol});
        cnt_line  += int'(line_start);
        cnt_frame += int'(frame_start);
        cnt_hs    += int'(hsync == HPOL);
        cnt_vs    += int'(vsync == VPOL);
        cnt_act   += int'(active);
        cnt_abc   += int'(active && {red_out, green_out, blue_out} == 12'hABC);
        cnt_blank_col += int'(!active && {red_out, green_out, blue_out} != 12'h000);
    endtask

    task automatic cycle(input logic en_v);
        en      = en_v;
        rgb_in  = use_fixed ? fixed_rgb : 12'($urandom);
        cur_rgb = rgb_in;
        @(posedge clk25);
        #1;
        x2 = x1; y2 = y1; r2 = r1;
        x1 = x0; y1 = y0; r1 = r0;
        rgb1 = cur_rgb;
        if (en_v) n = r0 ? n + 1 : 0;
        r0 = en_v;
        x0 = n % HT;
        y0 = (n / HT) % VT;
        check_cycle();
    endtask

    task automatic clear_counts();
        cnt_line = 0; cnt_frame = 0; cnt_hs = 0; cnt_vs = 0;
        cnt_act = 0; cnt_abc = 0; cnt_blank_col = 0;
    endtask

    // Called just after a clock edge; reset is checked before any further edge.
    task automatic do_reset();
        en    = 1'b0;
        rst_n = 1'b0;
        #2;
        cmp("async_reset",
            {pix_x, pix_y, pix_req, frame_start, line_start, active,
             red_out, green_out, blue_out, hsync, vsync},
            {{XW{1'b0}}, {YW{1'b0}}, 4'b0000, 12'h000, ~HPOL, ~VPOL});
        @(posedge clk25);
        #1;
        rst_n = 1'b1;
        r0 = 0; r1 = 0; r2 = 0; n = 0;
    endtask

    vec_t tv [6];

    initial begin
        int drop;
        tv[0] = '{1,            1,      1, 0,      0,      0};
        tv[1] = '{HA + 2,       1,      1, 0,      0,      HA};
        tv[2] = '{HA+HFP+HS+2,  1,      1, HS,     0,      HA};
        tv[3] = '{HT + 2,       2,      1, HS,     0,      HA};
        tv[4] = '{FT + 2,       VT + 1, 2, HS*VT,  VS*HT,  HA*VA};
        tv[5] = '{2*FT + 2,     2*VT+1, 3, 2*HS*VT,2*VS*HT,2*HA*VA};

        @(posedge clk25);
        #1;
        do_reset();

        // Idle hold: nothing moves with en low.
        for (int i = 0; i < 1000; i++) cycle(1'b0);

        // Table of runs from reset: pulse and active-level counts per run length.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            cycle(1'b0);
            clear_counts();
            for (int i = 0; i < tv[v].cycles; i++) cycle(1'b1);
            cmp($sformatf("tbl%0d_line", v),  64'(cnt_line),  64'(tv[v].e_line));
            cmp($sformatf("tbl%0d_frame", v), 64'(cnt_frame), 64'(tv[v].e_frame));
            cmp($sformatf("tbl%0d_hs", v),    64'(cnt_hs),    64'(tv[v].e_hs));
            cmp($sformatf("tbl%0d_vs", v),    64'(cnt_vs),    64'(tv[v].e_vs));
            cmp($sformatf("tbl%0d_act", v),   64'(cnt_act),   64'(tv[v].e_act));
        end

        // Fixed colour source over two lines.
        do_reset();
        use_fixed = 1'b1;
        clear_counts();
        for (int i = 0; i < 2 * HT + 2; i++) cycle(1'b1);
        cmp("abc_count", 64'(cnt_abc), 64'(2 * HA));
        cmp("blank_colour", 64'(cnt_blank_col), 64'd0);
        use_fixed = 1'b0;

        // Stop mid-line, drain, restart, then asynchronous reset at (40,20).
        do_reset();
        for (int i = 0; i < 31; i++) cycle(1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0);
        cycle(1'b1);
        cmp("restart", {frame_start, line_start, pix_x, pix_y},
            {2'b11, {XW{1'b0}}, {YW{1'b0}}});
        for (int i = 0; i < 20 * HT + 40; i++) cycle(1'b1);
        cmp("pos_40_20", {pix_x, pix_y}, {XW'(40), YW'(20)});
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0);

        // Randomized colour and occasional enable drops against the model.
        drop = 0;
        for (int i = 0; i < 6000; i++) begin
            if (drop == 0 && $urandom_range(0, 399) == 0) drop = $urandom_range(1, 4);
            if (drop > 0) begin
                drop--;
                cycle(1'b0);
            end else begin
                cycle(1'b1);
            end
        end

`ifdef VGA_TESTPATTERN_EN
        for (int m = 1; m < 4; m++) begin
            do_reset();
            test_mode = 2'(m);
            for (int i = 0; i < HT * VA + 2; i++) cycle(1'b1);
        end
        do_reset();
        test_mode = 2'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
